// File: rtl/ccl_table_sequencer.sv
// ccl_table_sequencer: frame-level owner of the CCL equivalence and area tables.
// During active video the labeling datapath holds the write path. During
// blanking this block flattens every used label to its final root, holds the
// result for the relabel stage, then restores the identity mapping.
module ccl_table_sequencer #(
  parameter int unsigned MAX_LABELS = 1024,
  parameter int unsigned LABEL_W    = $clog2(MAX_LABELS)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  input  logic               frame_end_in,
  input  logic [LABEL_W:0]   num_labels_in,
  input  logic               resolve_done_in,
  output logic [LABEL_W-1:0] tbl_rd_addr_out,
  input  logic [LABEL_W-1:0] tbl_rd_data_in,
  output logic               tbl_wr_en_out,
  output logic [LABEL_W-1:0] tbl_wr_addr_out,
  output logic [LABEL_W-1:0] tbl_wr_data_out,
  output logic               area_clr_out,
  output logic               datapath_grant_out,
  output logic               busy_out,
  output logic               ready_out,
  output logic [LABEL_W:0]   num_roots_out,
  output logic               overflow_out,
  output logic               frame_drop_out
);

  typedef enum logic [2:0] {
    INIT_CLEAR,
    IDLE,
    ACTIVE,
    FL_RD1,
    FL_RD2,
    FL_WR,
    READY,
    CLEAR
  } state_t;

  localparam logic [LABEL_W-1:0] LAST_LABEL = LABEL_W'(MAX_LABELS - 1);
  localparam logic [LABEL_W:0]   MAX_N      = (LABEL_W + 1)'(MAX_LABELS - 1);

  state_t             state_q, state_d;
  logic [LABEL_W-1:0] idx_q, idx_d;
  logic [LABEL_W-1:0] n_q, n_d;
  logic [LABEL_W:0]   roots_q, roots_d;
  logic [LABEL_W-1:0] rd_addr_q, rd_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [LABEL_W-1:0] wr_addr_q, wr_addr_d;
  logic [LABEL_W-1:0] wr_data_q, wr_data_d;
  logic               area_clr_q, area_clr_d;
  logic               grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;
  logic               drop_q, drop_d;

  logic               clamp;
  logic [LABEL_W-1:0] n_clamped;

  assign clamp     = (num_labels_in > MAX_N);
  assign n_clamped = clamp ? LAST_LABEL : num_labels_in[LABEL_W-1:0];

  // Next-state and next-output logic. Outputs are registered from the decision
  // made this cycle, so writes appear one cycle after the state that issues them;
  // busy is held through that trailing write so it falls after the last one.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    roots_d    = roots_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    area_clr_d = 1'b0;
    drop_d     = frame_start_in && (state_q != IDLE);

    case (state_q)
      INIT_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = idx_q;
        wr_data_d  = idx_q;
        area_clr_d = 1'b1;
        if (idx_q == LAST_LABEL) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + LABEL_W'(1);
        end
      end
      IDLE: begin
        if (frame_start_in) begin
          overflow_d = 1'b0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_end_in) begin
          n_d     = n_clamped;
          roots_d = '0;
          if (clamp) overflow_d = 1'b1;
          if (n_clamped == '0) begin
            state_d = READY;
          end else begin
            idx_d   = LABEL_W'(1);
            state_d = FL_RD1;
          end
        end
      end
      FL_RD1: state_d = FL_RD2;
      FL_RD2: state_d = FL_WR;
      FL_WR: begin
        // equiv[p] was finalised earlier in the ascending pass, so it is the root.
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = tbl_rd_data_in;
        if (tbl_rd_data_in == idx_q) roots_d = roots_q + (LABEL_W + 1)'(1);
        if (idx_q == n_q) begin
          state_d = READY;
        end else begin
          idx_d   = idx_q + LABEL_W'(1);
          state_d = FL_RD1;
        end
      end
      READY: begin
        if (resolve_done_in) begin
          idx_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = idx_q;
        wr_data_d  = idx_q;
        area_clr_d = 1'b1;
        if (idx_q == n_q) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + LABEL_W'(1);
        end
      end
      default: state_d = INIT_CLEAR;
    endcase

    grant_d   = (state_d == ACTIVE);
    ready_d   = (state_d == READY);
    busy_d    = wr_en_d || !((state_d == IDLE) || (state_d == ACTIVE));
    rd_addr_d = (state_d == FL_RD1) ? idx_d : '0;
  end

  // State and registered outputs; reset restarts the table initialisation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= INIT_CLEAR;
      idx_q      <= '0;
      n_q        <= '0;
      roots_q    <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      area_clr_q <= 1'b0;
      grant_q    <= 1'b0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      roots_q    <= roots_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      area_clr_q <= area_clr_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // The parent read must chase the returned data in the same cycle.
  assign tbl_rd_addr_out    = (state_q == FL_RD2) ? tbl_rd_data_in : rd_addr_q;
  assign tbl_wr_en_out      = wr_en_q;
  assign tbl_wr_addr_out    = wr_addr_q;
  assign tbl_wr_data_out    = wr_data_q;
  assign area_clr_out       = area_clr_q;
  assign datapath_grant_out = grant_q;
  assign busy_out           = busy_q;
  assign ready_out          = ready_q;
  assign num_roots_out      = roots_q;
  assign overflow_out       = overflow_q;
  assign frame_drop_out     = drop_q;

endmodule
